drawing_de_arbiter: RTL and testbench
=====================================

Name: drawing_de_arbiter

Overview:
- Round-robin arbiter sharing the single frame-store drawing-engine port (de_* bus) among NREQ drawing units (rectangle, line, blit, ...).
- Each unit drives its own de_* request bundle as if it owned the port. The arbiter grants one unit at a time and muxes that unit onto the memory side.
- It routes de_ack back to the granted unit only and broadcasts read data.
- A burst limit stops one unit (e.g. a large rectangle fill) from starving the others.

Parameters:
- NREQ, 4, number of requesting drawing units (legal 2..8).
- MAX_BURST, 16, maximum acknowledged transfers per grant before forced release (legal 1..255; 0 = unlimited).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- rq_de_req  in  NREQ  per-unit transfer request
- rq_de_ack  out  NREQ  per-unit transfer acknowledge
- rq_de_addr  in  NREQ*18  per-unit word address, unit i at bits [18i+17:18i]
- rq_de_nbyte  in  NREQ*4  per-unit active-low byte enables
- rq_de_rnw  in  NREQ  per-unit read-not-write
- rq_de_w_data  in  NREQ*32  per-unit write data
- rq_de_r_data  out  32  read data, broadcast to all units
- de_req  out  1  memory-side request
- de_ack  in  1  memory-side acknowledge, one pulse per completed transfer
- de_addr  out  18  memory-side address
- de_nbyte  out  4  memory-side byte enables
- de_rnw  out  1  memory-side read-not-write
- de_w_data  out  32  memory-side write data
- de_r_data  in  32  memory-side read data
- grant  out  NREQ  one-hot current owner, all-zero when idle
- busy  out  1  high while in GRANT state

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, grant=0, ptr=0 (highest priority to unit 0), burst_cnt=0.
  - de_req=0, all rq_de_ack=0, busy=0.
  - de_addr/de_nbyte/de_rnw/de_w_data=0.
- States: IDLE, GRANT.
- IDLE:
  - If any rq_de_req bit is set, select the first set bit searching from ptr upward, modulo NREQ.
  - Register its one-hot into grant, clear burst_cnt, go to GRANT.
  - Latency: request seen at edge N, grant and de_req visible after edge N+1.
- GRANT: the memory side is driven combinationally from the granted unit.
  - de_req = rq_de_req[g].
  - de_addr, de_nbyte, de_rnw, de_w_data = unit g fields.
  - rq_de_ack[g] = de_ack; all other acks are 0.
  - rq_de_r_data = de_r_data at all times.
- Burst counting: each cycle with de_ack=1 increments burst_cnt (8 bits, saturating).
- Release conditions (any one returns the arbiter to IDLE at the next edge, clears grant, and sets ptr=g+1 mod NREQ):
  - (a) rq_de_req[g]=0.
  - (b) de_ack=1 and burst_cnt+1==MAX_BURST (MAX_BURST≠0).
  - (c) de_ack=1 and rq_de_req[g] is not expected to stay high: the unit handles this by dropping req; the arbiter needs no extra logic.
- Release timing: one dead IDLE cycle between grants is mandatory; de_req is 0 in that cycle.
- Idle outputs: outside GRANT, de_req=0 and memory-side data outputs hold 0.
- Forced release: a unit released mid-burst keeps de_req high and simply waits. It re-wins when round-robin reaches it again; no transfer is lost, because the ack for its last transfer was already delivered.
- Simultaneous requests: the unit nearest ptr upward wins. Example with NREQ=4, ptr=2 and requests 0 and 3 both pending: unit 3 wins.
- Single requester: it is regranted after each forced release, at one dead cycle per MAX_BURST transfers.
- Unit drops req without ack: release per (a); the memory side sees de_req fall. The memory controller must tolerate this.
- de_ack while IDLE is ignored: not routed, burst_cnt unchanged.
- Reset mid-transfer: grant, de_req and acks drop immediately, asynchronously. Any in-flight memory transfer is abandoned.
- Units must hold addr/data stable while de_req=1 until the ack cycle. The arbiter does not check this.

Decomposition:
- Shared package drawing_pkg holds:
  - DE_ADDR_W=18, DE_DATA_W=32, DE_NBYTE_W=4.
  - State encoding ARB_IDLE=0, ARB_GRANT=1.
  - The de-bus field widths, for reuse by all drawing units.
- One sub-module: drawing_rr_pick. It is purely combinational: inputs req[NREQ] and ptr; outputs one-hot pick and a valid flag. It is reused by any future command dispatcher.

Test Plan:
- Reset, no requests -> grant=0, de_req=0, busy=0; assert rst_n=0 mid-GRANT -> de_req=0 in the same cycle.
- Unit 1 only, 5 writes addr 0x00100.. with de_ack every other cycle -> grant=0010 one cycle after req, 5 acks on rq_de_ack[1] only, de_addr matches unit 1.
- Units 0, 2, 3 request together from reset -> grants in order 0, 2, 3, with one idle cycle between each grant.
- MAX_BURST=4, unit 0 requests 10 transfers, unit 2 requests 2 -> unit 0 gets 4 acks, unit 2 gets 2, then unit 0 gets 4 more, then the remaining 2.
- Unit 3 drops req with no ack while granted -> release next edge, ptr=0, no ack issued.
- Read: unit 2 rnw=1, de_r_data=0xDEADBEEF on the ack cycle -> rq_de_r_data=0xDEADBEEF, only rq_de_ack[2]=1.

Source files
------------

// File: rtl/drawing_pkg.sv
// -----------------------------------------------------------------------------
// drawing_pkg
// Shared definitions for the frame-store drawing engine bus (de_* bus).
// Drawing units, the port arbiter and future command dispatchers import this.
//
// Contents:
//   DE_ADDR_W / DE_DATA_W / DE_NBYTE_W : de-bus field widths
//   BURST_CNT_W                        : width of the arbiter burst counter
//   arb_state_e                        : arbiter state encoding
//   de_bus_t                           : one unit's request bundle
//   arb_dbg_t                          : arbiter debug view (state, ptr, burst)
//   sat_inc()                          : saturating increment for the counter
// -----------------------------------------------------------------------------
package drawing_pkg;

    localparam int DE_ADDR_W   = 18;
    localparam int DE_DATA_W   = 32;
    localparam int DE_NBYTE_W  = 4;
    localparam int BURST_CNT_W = 8;
    // Wide enough for a pointer into the largest legal unit count (8).
    localparam int DBG_PTR_W   = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // One drawing unit's view of the de-bus (request side).
    typedef struct packed {
        logic                  req;
        logic [DE_ADDR_W-1:0]  addr;
        logic [DE_NBYTE_W-1:0] nbyte;   // active-low byte enables
        logic                  rnw;
        logic [DE_DATA_W-1:0]  w_data;
    } de_bus_t;

    // Internal state exported for debug and checker binding.
    typedef struct packed {
        arb_state_e             state;
        logic [DBG_PTR_W-1:0]   ptr;
        logic [BURST_CNT_W-1:0] burst_cnt;
    } arb_dbg_t;

    function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/drawing_de_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// drawing_rr_pick
// Purely combinational round-robin selector. Starting at ptr_i and searching
// upward modulo NREQ, returns the first set bit of req_i as a one-hot pick.
//
// Ports:
//   req_i   [NREQ]   request vector
//   ptr_i   [PTR_W]  highest-priority index (must be < NREQ)
//   pick_o  [NREQ]   one-hot winner, all-zero when no request
//   valid_o          at least one request present
// -----------------------------------------------------------------------------
module drawing_rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  pick_o,
    output logic             valid_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk the NREQ candidate positions in priority order. The wrap is done
    // by a single conditional subtract so non-power-of-two NREQ works.
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drawing_de_arbiter.sv
// -----------------------------------------------------------------------------
// drawing_de_arbiter
// Round-robin arbiter sharing the single frame-store de_* port among NREQ
// drawing units. One unit owns the port at a time; its bundle is muxed to the
// memory side, de_ack is routed back to it alone and read data is broadcast.
// A burst limit forces release after MAX_BURST acknowledged transfers.
//
// Handshake: a unit holds rq_de_req high with stable addr/data until it sees
// its rq_de_ack pulse; each de_ack pulse completes exactly one transfer of the
// granted unit. de_req follows the granted unit's request while in GRANT and
// is 0 otherwise.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   rq_de_req/ack/addr/nbyte/rnw/
//   rq_de_w_data/rq_de_r_data         per-unit side (flat, unit i at slice i)
//   de_req/ack/addr/nbyte/rnw/
//   de_w_data/de_r_data               memory side
//   grant                             one-hot owner, zero when idle
//   busy                              high in GRANT
//   dbg_o                             state, round-robin pointer, burst count
// -----------------------------------------------------------------------------
module drawing_de_arbiter
    import drawing_pkg::*;
#(
    parameter int NREQ      = 4,    // 2..8
    parameter int MAX_BURST = 16    // 1..255, 0 = unlimited
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            rq_de_req,
    output logic [NREQ-1:0]            rq_de_ack,
    input  logic [NREQ*DE_ADDR_W-1:0]  rq_de_addr,
    input  logic [NREQ*DE_NBYTE_W-1:0] rq_de_nbyte,
    input  logic [NREQ-1:0]            rq_de_rnw,
    input  logic [NREQ*DE_DATA_W-1:0]  rq_de_w_data,
    output logic [DE_DATA_W-1:0]       rq_de_r_data,
    output logic                       de_req,
    input  logic                       de_ack,
    output logic [DE_ADDR_W-1:0]       de_addr,
    output logic [DE_NBYTE_W-1:0]      de_nbyte,
    output logic                       de_rnw,
    output logic [DE_DATA_W-1:0]       de_w_data,
    input  logic [DE_DATA_W-1:0]       de_r_data,
    output logic [NREQ-1:0]            grant,
    output logic                       busy,
    output arb_dbg_t                   dbg_o
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_e             state_q, state_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    de_bus_t                unit_bus [NREQ];
    de_bus_t                sel_bus;
    logic [PTR_W-1:0]       g_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic [NREQ-1:0]        pick;
    logic                   pick_valid;
    logic                   burst_done;
    logic                   release_c;

    // ---------------------------------------------------------------- unpack
    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign unit_bus[k] = {rq_de_req[k],
                              rq_de_addr[k*DE_ADDR_W +: DE_ADDR_W],
                              rq_de_nbyte[k*DE_NBYTE_W +: DE_NBYTE_W],
                              rq_de_rnw[k],
                              rq_de_w_data[k*DE_DATA_W +: DE_DATA_W]};
    end

    // ------------------------------------------------------ round-robin pick
    drawing_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i   (rq_de_req),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    // Index of the current owner; grant_q is one-hot in GRANT.
    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                g_idx = PTR_W'(k);
            end
        end
    end

    assign sel_bus  = unit_bus[g_idx];
    assign next_ptr = (g_idx == PTR_W'(NREQ-1)) ? '0 : g_idx + PTR_W'(1);

    // The ack that brings the count to MAX_BURST is the last one this grant.
    assign burst_done = de_ack && (MAX_BURST != 0) &&
                        (({1'b0, burst_cnt_q} + 9'd1) == 9'(MAX_BURST));

    // A unit that has dropped its request gives the port up as well.
    assign release_c  = !sel_bus.req || burst_done;

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (de_ack) begin
                    burst_cnt_d = sat_inc(burst_cnt_q);
                end
                // Releasing always passes through IDLE, which yields the
                // mandatory dead cycle before the next owner is granted.
                if (release_c) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // --------------------------------------------------------------- outputs
    // Everything below derives from registered state, so an asynchronous
    // reset drops de_req, grant and the acks in the same cycle.
    always_comb begin
        busy      = (state_q == ARB_GRANT);
        de_req    = 1'b0;
        de_addr   = '0;
        de_nbyte  = '0;
        de_rnw    = 1'b0;
        de_w_data = '0;
        rq_de_ack = '0;
        if (busy) begin
            de_req    = sel_bus.req;
            de_addr   = sel_bus.addr;
            de_nbyte  = sel_bus.nbyte;
            de_rnw    = sel_bus.rnw;
            de_w_data = sel_bus.w_data;
            rq_de_ack = de_ack ? grant_q : '0;
        end
    end

    assign rq_de_r_data    = de_r_data;
    assign grant           = grant_q;
    assign dbg_o.state     = state_q;
    assign dbg_o.ptr       = DBG_PTR_W'(ptr_q);
    assign dbg_o.burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_drawing_de_arbiter.sv
module tb_drawing_de_arbiter;
  import drawing_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXB = 4;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]            rq_de_req;
  logic [NREQ-1:0]            rq_de_ack;
  logic [NREQ*DE_ADDR_W-1:0]  rq_de_addr;
  logic [NREQ*DE_NBYTE_W-1:0] rq_de_nbyte;
  logic [NREQ-1:0]            rq_de_rnw;
  logic [NREQ*DE_DATA_W-1:0]  rq_de_w_data;
  logic [DE_DATA_W-1:0]       rq_de_r_data;
  logic                       de_req;
  logic                       de_ack;
  logic [DE_ADDR_W-1:0]       de_addr;
  logic [DE_NBYTE_W-1:0]      de_nbyte;
  logic                       de_rnw;
  logic [DE_DATA_W-1:0]       de_w_data;
  logic [DE_DATA_W-1:0]       de_r_data;
  logic [NREQ-1:0]            grant;
  logic                       busy;
  arb_dbg_t                   dbg;

  drawing_de_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rq_de_req    (rq_de_req),
    .rq_de_ack    (rq_de_ack),
    .rq_de_addr   (rq_de_addr),
    .rq_de_nbyte  (rq_de_nbyte),
    .rq_de_rnw    (rq_de_rnw),
    .rq_de_w_data (rq_de_w_data),
    .rq_de_r_data (rq_de_r_data),
    .de_req       (de_req),
    .de_ack       (de_ack),
    .de_addr      (de_addr),
    .de_nbyte     (de_nbyte),
    .de_rnw       (de_rnw),
    .de_w_data    (de_w_data),
    .de_r_data    (de_r_data),
    .grant        (grant),
    .busy         (busy),
    .dbg_o        (dbg)
  );

  // ------------------------------------------------------ bench-side state
  // Drawing units: remaining transfers and the transfer currently presented.
  int               rem  [NREQ];
  bit               hold [NREQ];
  logic [17:0]      ua   [NREQ];
  logic [31:0]      uw   [NREQ];
  logic [3:0]       un   [NREQ];
  logic             ur   [NREQ];
  bit               seq_addr;

  // Reference model of the port owner: -1 means nobody.
  int               m_owner, m_ptr, m_cnt;

  int               ack_mode;   // 0 none, 1 every cycle, 2 alternate, 3 random
  int               cyc;
  bit               force_rd;
  int               n_checks, n_fail;

  logic [7:0]       exp_q[$];
  logic [7:0]       exp_g[$];
  logic [7:0]       ack_obs[$];
  logic [7:0]       gnt_obs[$];
  logic [NREQ-1:0]  prev_grant;

  // --------------------------------------------------------------- checking
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_queue(input string tag, input logic [7:0] obs[$], input logic [7:0] exp[$]);
    check_eq({tag, "_len"}, 64'(obs.size()), 64'(exp.size()));
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      check_eq({tag, "_item"}, 64'(obs[i]), 64'(exp[i]));
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_units();
    for (int i = 0; i < NREQ; i++) begin
      rq_de_req[i]                  = (rem[i] > 0) && !hold[i];
      rq_de_addr[i*18 +: 18]        = ua[i];
      rq_de_nbyte[i*4 +: 4]         = un[i];
      rq_de_rnw[i]                  = ur[i];
      rq_de_w_data[i*32 +: 32]      = uw[i];
    end
  endtask

  task automatic new_xfer(input int i);
    ua[i] = seq_addr ? ua[i] + 18'd1 : 18'($urandom);
    uw[i] = $urandom;
    un[i] = 4'($urandom_range(0, 15));
    if (!seq_addr) ur[i] = 1'($urandom_range(0, 1));
  endtask

  function automatic int first_from(input int ptr, input logic [NREQ-1:0] req);
    for (int k = 0; k < NREQ; k++)
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic check_outputs();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ea;
    eg = '0;
    ea = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (de_ack) ea[m_owner] = 1'b1;
    end
    check_eq("grant", 64'(grant), 64'(eg));
    check_eq("busy", 64'(busy), 64'(m_owner >= 0));
    check_eq("dbg_state", 64'(dbg.state), 64'(m_owner >= 0));
    check_eq("dbg_ptr", 64'(dbg.ptr), 64'(m_ptr));
    check_eq("rq_de_ack", 64'(rq_de_ack), 64'(ea));
    check_eq("r_data", 64'(rq_de_r_data), 64'(de_r_data));
    if (m_owner >= 0) begin
      check_eq("dbg_burst", 64'(dbg.burst_cnt), 64'(m_cnt));
      check_eq("de_req", 64'(de_req), 64'(rq_de_req[m_owner]));
      check_eq("de_addr", 64'(de_addr), 64'(ua[m_owner]));
      check_eq("de_nbyte", 64'(de_nbyte), 64'(un[m_owner]));
      check_eq("de_rnw", 64'(de_rnw), 64'(ur[m_owner]));
      check_eq("de_w_data", 64'(de_w_data), 64'(uw[m_owner]));
    end else begin
      check_eq("idle_de_req", 64'(de_req), 64'd0);
      check_eq("idle_de_bus", 64'({de_addr, de_nbyte, de_rnw, de_w_data}), 64'd0);
    end
    for (int i = 0; i < NREQ; i++)
      if (rq_de_ack[i]) ack_obs.push_back(8'(i));
    if (grant != 0 && prev_grant == 0)
      for (int i = 0; i < NREQ; i++)
        if (grant[i]) gnt_obs.push_back(8'(i));
    prev_grant = grant;
  endtask

  // One clock: memory stimulus at negedge, checks, model update at posedge,
  // units react just after the edge.
  task automatic step_cycle();
    @(negedge clk);
    case (ack_mode)
      1:       de_ack = 1'b1;
      2:       de_ack = cyc[0];
      3:       de_ack = 1'($urandom_range(0, 1));
      default: de_ack = 1'b0;
    endcase
    if (m_owner >= 0 && !rq_de_req[m_owner]) de_ack = 1'b0;
    if (ack_mode != 3 && m_owner < 0) de_ack = 1'b0;
    cyc++;
    de_r_data = force_rd ? 32'hDEADBEEF : $urandom;
    #1;
    check_outputs();
    @(posedge clk);
    if (m_owner < 0) begin
      int j;
      j = first_from(m_ptr, rq_de_req);
      if (j >= 0) begin
        m_owner = j;
        m_cnt   = 0;
      end
    end else begin
      bit rel;
      rel = !rq_de_req[m_owner] || (de_ack && MAXB != 0 && m_cnt + 1 == MAXB);
      if (de_ack && m_cnt < 255) m_cnt++;
      if (de_ack && rq_de_req[m_owner] && rem[m_owner] > 0) begin
        rem[m_owner]--;
        if (rem[m_owner] > 0) new_xfer(m_owner);
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
    #1;
    drive_units();
  endtask

  function automatic bit units_pending();
    for (int i = 0; i < NREQ; i++)
      if (rem[i] > 0 && !hold[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((units_pending() || m_owner >= 0) && k < budget) begin
      step_cycle();
      k++;
    end
    if (k >= budget) check_eq("timeout", 64'd1, 64'd0);
  endtask

  // Asserts reset at the current time, checks the asynchronous response,
  // then releases it and returns just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_de_req", 64'(de_req), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ack", 64'(rq_de_ack), 64'd0);
    check_eq("rst_bus", 64'({de_addr, de_nbyte, de_rnw, de_w_data}), 64'd0);
    check_eq("rst_dbg", 64'(dbg), 64'd0);
    de_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]  = 0;
      hold[i] = 1'b0;
    end
    drive_units();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_grant = '0;
    ack_obs.delete();
    gnt_obs.delete();
    exp_q.delete();
    exp_g.delete();
  endtask

  // ------------------------------------------------------------------ tests
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    force_rd = 1'b0;
    seq_addr = 1'b1;
    ack_mode = 0;
    de_ack   = 1'b0;
    de_r_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; hold[i] = 1'b0;
      ua[i] = 18'(i * 18'h01000); uw[i] = 32'(i); un[i] = 4'h0; ur[i] = 1'b0;
    end
    drive_units();
    #2;
    do_reset();

    // Idle with no requests.
    repeat (3) step_cycle();

    // Unit 1 alone, five sequential writes, ack every other cycle.
    @(negedge clk);
    do_reset();
    ack_mode = 2;
    ua[1] = 18'h00100; uw[1] = 32'h1111_0000; un[1] = 4'h0; ur[1] = 1'b0;
    rem[1] = 5;
    drive_units();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'd1);
    wait_done(200);
    check_queue("u1_acks", ack_obs, exp_q);
    check_eq("u1_last_addr", 64'(ua[1]), 64'h00104);

    // Units 0, 2 and 3 together from reset.
    @(negedge clk);
    do_reset();
    ack_mode = 1;
    rem[0] = 1; rem[2] = 1; rem[3] = 1;
    drive_units();
    exp_g = '{8'd0, 8'd2, 8'd3};
    exp_q = '{8'd0, 8'd2, 8'd3};
    wait_done(200);
    check_queue("rr_grants", gnt_obs, exp_g);
    check_queue("rr_acks", ack_obs, exp_q);

    // Burst limit: unit 0 wants 10, unit 2 wants 2.
    @(negedge clk);
    do_reset();
    ack_mode = 1;
    rem[0] = 10; rem[2] = 2;
    drive_units();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'd0);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd2);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'd0);
    exp_g = '{8'd0, 8'd2, 8'd0, 8'd0};
    wait_done(300);
    check_queue("burst_acks", ack_obs, exp_q);
    check_queue("burst_grants", gnt_obs, exp_g);

    // Unit 3 drops its request without an ack, then competes with unit 0.
    @(negedge clk);
    do_reset();
    ack_mode = 0;
    rem[3] = 3;
    drive_units();
    for (int k = 0; k < 10 && m_owner != 3; k++) step_cycle();
    repeat (2) step_cycle();
    check_eq("drop_owner", 64'(grant), 64'b1000);
    hold[3] = 1'b1;
    drive_units();
    step_cycle();
    check_eq("drop_no_ack", 64'(ack_obs.size()), 64'd0);
    hold[3] = 1'b0;
    rem[0] = 1;
    ack_mode = 1;
    drive_units();
    exp_g = '{8'd3, 8'd0, 8'd3};
    exp_q = '{8'd0, 8'd3, 8'd3, 8'd3};
    wait_done(200);
    check_queue("drop_grants", gnt_obs, exp_g);
    check_queue("drop_acks", ack_obs, exp_q);

    // Read by unit 2 with fixed return data.
    @(negedge clk);
    do_reset();
    ack_mode = 1;
    force_rd = 1'b1;
    ua[2] = 18'h2ABCD; ur[2] = 1'b1;
    rem[2] = 1;
    drive_units();
    exp_q = '{8'd2};
    wait_done(50);
    check_queue("read_acks", ack_obs, exp_q);
    force_rd = 1'b0;

    // Randomized traffic, including acks that arrive while idle.
    seq_addr = 1'b0;
    ack_mode = 3;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          rem[i] = $urandom_range(1, 9);
          new_xfer(i);
        end
      end
      drive_units();
      wait_done(800);
      repeat ($urandom_range(0, 3)) step_cycle();
    end

    // Reset asserted while a unit owns the port.
    ack_mode = 1;
    rem[1] = 6;
    rem[3] = 6;
    drive_units();
    for (int k = 0; k < 10 && m_owner < 0; k++) step_cycle();
    step_cycle();
    check_eq("pre_rst_de_req", 64'(de_req), 64'd1);
    de_ack = 1'b1;
    #2;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
